hnf_pocq_tracker: RTL and testbench

Parametrised point-of-coherence queue for the HN-F. It allocates one tracker entry per accepted request and stalls requests to a cache line that already has an entry in flight. Each entry lives until its response is issued and, when ExpCompAck is set, until the matching CompAck returns. Sits between the rxreq slice pipe and the SLC/SF lookup. The entry index is used as the DBID on responses.

---
 rtl/hnf_pocq_tracker_if.sv | 46 ++++
 rtl/hnf_pocq_tracker.sv | 169 ++++++++++++++++
 tb/tb_hnf_pocq_tracker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hnf_pocq_tracker_if.sv
// Request/response bus of the HN-F point-of-coherence queue.
// The master side offers requests, completions and CompAcks; the slave side
// is the tracker, which returns grant, hazard, lookup data and occupancy.
interface hnf_pocq_tracker_if #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 48,
  parameter int NODEID_W = 7,
  parameter int TXNID_W  = 8,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
);
  logic                alloc_valid;
  logic                alloc_ready;
  logic [ADDR_W-1:0]   alloc_addr;
  logic [NODEID_W-1:0] alloc_srcid;
  logic [TXNID_W-1:0]  alloc_txnid;
  logic                alloc_expcompack;
  logic [IDX_W-1:0]    alloc_idx;
  logic                alloc_hazard;
  logic                done_valid;
  logic [IDX_W-1:0]    done_idx;
  logic                compack_valid;
  logic [IDX_W-1:0]    compack_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [NODEID_W-1:0] rd_srcid;
  logic [TXNID_W-1:0]  rd_txnid;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                err;

  modport master (
    output alloc_valid, alloc_addr, alloc_srcid, alloc_txnid, alloc_expcompack,
    output done_valid, done_idx, compack_valid, compack_idx, rd_idx,
    input  alloc_ready, alloc_idx, alloc_hazard,
    input  rd_addr, rd_srcid, rd_txnid, count, full, empty, err
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_srcid, alloc_txnid, alloc_expcompack,
    input  done_valid, done_idx, compack_valid, compack_idx, rd_idx,
    output alloc_ready, alloc_idx, alloc_hazard,
    output rd_addr, rd_srcid, rd_txnid, count, full, empty, err
  );
endinterface

// File: rtl/hnf_pocq_tracker.sv
// HN-F point-of-coherence queue tracker.
// One entry per accepted request; a request whose cache line already has a
// live entry is held off. Entries retire on their response, or on the
// returning CompAck when the request asked for one. The entry index doubles
// as the DBID handed out on responses.
module hnf_pocq_tracker #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 48,
  parameter int LINE_OFF = 6,
  parameter int NODEID_W = 7,
  parameter int TXNID_W  = 8,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic                clock,
  input logic                reset,
  hnf_pocq_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } entry_state_e;

  entry_state_e        state_reg  [DEPTH];
  entry_state_e        state_next [DEPTH];

  // Payload is written only on allocation and never reset; it is only
  // meaningful while the owning entry is live.
  logic [ADDR_W-1:0]   addr_mem   [DEPTH];
  logic [NODEID_W-1:0] srcid_mem  [DEPTH];
  logic [TXNID_W-1:0]  txnid_mem  [DEPTH];
  logic                exp_mem    [DEPTH];

  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    count_next;
  logic                full_reg;
  logic                empty_reg;
  logic                err_reg;

  logic [DEPTH-1:0]    live;
  logic [DEPTH-1:0]    line_hit;
  logic                hazard;
  logic                any_idle;
  logic [IDX_W-1:0]    free_idx;
  logic                alloc_hs;

  entry_state_e        done_state;
  entry_state_e        ack_state;
  logic                done_ok;
  logic                done_free;
  logic                done_err;
  logic                ack_ok;
  logic                ack_err;

  // Per-entry liveness and same-line match against the offered request.
  // An entry retiring this cycle is still live, so its line stays blocked
  // until the edge has actually freed it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign live[gi]     = (state_reg[gi] != ST_IDLE);
      assign line_hit[gi] = live[gi] &&
                            (addr_mem[gi][ADDR_W-1:LINE_OFF] ==
                             bus.alloc_addr[ADDR_W-1:LINE_OFF]);
    end
  endgenerate

  assign hazard = |line_hit;

  // Lowest-index idle entry; scanning downward lets the lowest one win.
  always_comb begin
    free_idx = '0;
    any_idle = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_idx = IDX_W'(i);
        any_idle = 1'b1;
      end
    end
  end

  assign alloc_hs = bus.alloc_valid && any_idle && !hazard;

  // Classify completion and CompAck against the pre-edge entry state.
  // Both look at registered state only, so a same-index done+CompAck pair
  // sees ACTIVE for the CompAck and flags it.
  always_comb begin
    done_state = state_reg[bus.done_idx];
    ack_state  = state_reg[bus.compack_idx];
    done_ok    = bus.done_valid && (done_state == ST_ACTIVE);
    done_free  = done_ok && !exp_mem[bus.done_idx];
    done_err   = bus.done_valid && !done_ok;
    ack_ok     = bus.compack_valid && (ack_state == ST_WAIT_ACK);
    ack_err    = bus.compack_valid && !ack_ok;
  end

  // Next entry states. The allocation target is idle while done/CompAck
  // targets are not, and done needs ACTIVE while CompAck needs WAIT_ACK,
  // so the three updates never land on the same entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_next[i] = state_reg[i];
    end
    if (alloc_hs) begin
      state_next[free_idx] = ST_ACTIVE;
    end
    if (done_ok) begin
      state_next[bus.done_idx] = exp_mem[bus.done_idx] ? ST_WAIT_ACK : ST_IDLE;
    end
    if (ack_ok) begin
      state_next[bus.compack_idx] = ST_IDLE;
    end
  end

  assign count_next = count_reg + CNT_W'(alloc_hs)
                                - CNT_W'(done_free)
                                - CNT_W'(ack_ok);

  // Entry state register; reset drops every entry at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_reg[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_reg[i] <= state_next[i];
      end
    end
  end

  // Occupancy, full/empty flags and the one-cycle protocol error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
      err_reg   <= done_err || ack_err;
    end
  end

  // Capture the request payload into the granted entry.
  always_ff @(posedge clock) begin
    if (alloc_hs) begin
      addr_mem[free_idx]  <= bus.alloc_addr;
      srcid_mem[free_idx] <= bus.alloc_srcid;
      txnid_mem[free_idx] <= bus.alloc_txnid;
      exp_mem[free_idx]   <= bus.alloc_expcompack;
    end
  end

  assign bus.alloc_ready  = any_idle && !hazard;
  assign bus.alloc_idx    = free_idx;
  assign bus.alloc_hazard = hazard;
  assign bus.rd_addr      = addr_mem[bus.rd_idx];
  assign bus.rd_srcid     = srcid_mem[bus.rd_idx];
  assign bus.rd_txnid     = txnid_mem[bus.rd_idx];
  assign bus.count        = count_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.err          = err_reg;

endmodule

// File: tb/tb_hnf_pocq_tracker.sv
// Bench for hnf_pocq_tracker: directed stimulus, a set-of-live-entries model
// compared every cycle, and hand-computed checks at key points.
module tb_hnf_pocq_tracker;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 48;
  localparam int LINE_OFF = 6;
  localparam int NODEID_W = 7;
  localparam int TXNID_W  = 8;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  hnf_pocq_tracker_if #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NODEID_W(NODEID_W), .TXNID_W(TXNID_W)
  ) bus ();

  hnf_pocq_tracker #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_OFF(LINE_OFF),
    .NODEID_W(NODEID_W), .TXNID_W(TXNID_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: which entries hold a request, which still owe a CompAck, and
  // what each one stored.
  bit                  m_live  [DEPTH];
  bit                  m_wait  [DEPTH];
  bit                  m_exp   [DEPTH];
  logic [ADDR_W-1:0]   m_addr  [DEPTH];
  logic [NODEID_W-1:0] m_srcid [DEPTH];
  logic [TXNID_W-1:0]  m_txnid [DEPTH];
  bit                  m_err;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_live[i]) n++;
    return n;
  endfunction

  function automatic bit m_hazard(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < DEPTH; i++)
      if (m_live[i] && ((m_addr[i] >> LINE_OFF) == (a >> LINE_OFF))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < DEPTH; i++) if (!m_live[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update: rules applied to the state as it stood before the edge.
  always @(posedge clock or negedge reset) begin
    int  ff, d, c;
    bit  rdy, d_ok, c_ok;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_live[i] <= 1'b0;
        m_wait[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      ff   = m_first_free();
      rdy  = (ff >= 0) && !m_hazard(bus.alloc_addr);
      d    = int'(bus.done_idx);
      c    = int'(bus.compack_idx);
      d_ok = bus.done_valid && m_live[d] && !m_wait[d];
      c_ok = bus.compack_valid && m_live[c] && m_wait[c];
      m_err <= (bus.done_valid && !d_ok) || (bus.compack_valid && !c_ok);
      if (bus.alloc_valid && rdy) begin
        m_live[ff]  <= 1'b1;
        m_wait[ff]  <= 1'b0;
        m_exp[ff]   <= bus.alloc_expcompack;
        m_addr[ff]  <= bus.alloc_addr;
        m_srcid[ff] <= bus.alloc_srcid;
        m_txnid[ff] <= bus.alloc_txnid;
      end
      if (d_ok) begin
        if (m_exp[d]) m_wait[d] <= 1'b1;
        else          m_live[d] <= 1'b0;
      end
      if (c_ok) begin
        m_live[c] <= 1'b0;
        m_wait[c] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    int ff;
    bit hz;
    ff = m_first_free();
    hz = m_hazard(bus.alloc_addr);
    check("m_count", 64'(bus.count), 64'(m_count()));
    check("m_full", 64'(bus.full), 64'(m_count() == DEPTH));
    check("m_empty", 64'(bus.empty), 64'(m_count() == 0));
    check("m_err", 64'(bus.err), 64'(m_err));
    check("m_hazard", 64'(bus.alloc_hazard), 64'(hz));
    check("m_ready", 64'(bus.alloc_ready), 64'((ff >= 0) && !hz));
    if (ff >= 0) check("m_alloc_idx", 64'(bus.alloc_idx), 64'(ff));
    if (m_live[bus.rd_idx]) begin
      check("m_rd_addr", 64'(bus.rd_addr), 64'(m_addr[bus.rd_idx]));
      check("m_rd_srcid", 64'(bus.rd_srcid), 64'(m_srcid[bus.rd_idx]));
      check("m_rd_txnid", 64'(bus.rd_txnid), 64'(m_txnid[bus.rd_idx]));
    end
  end

  // Advance to just after the next rising edge; sweep the lookup index.
  task automatic step();
    @(posedge clock);
    #1;
    bus.rd_idx = bus.rd_idx + 1'b1;
  endtask

  task automatic offer(input logic [ADDR_W-1:0] a, input int tag, input bit exp);
    bus.alloc_valid      = 1'b1;
    bus.alloc_addr       = a;
    bus.alloc_srcid      = NODEID_W'(tag);
    bus.alloc_txnid      = TXNID_W'(tag + 8'h80);
    bus.alloc_expcompack = exp;
  endtask

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_addr = '0; bus.alloc_srcid = '0;
    bus.alloc_txnid = '0; bus.alloc_expcompack = 1'b0;
    bus.done_valid = 1'b0; bus.done_idx = '0;
    bus.compack_valid = 1'b0; bus.compack_idx = '0; bus.rd_idx = '0;
    #1 reset = 1'b0;
    #11;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_ready", 64'(bus.alloc_ready), 64'd1);
    check("rst_hazard", 64'(bus.alloc_hazard), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    @(negedge clock); #2 reset = 1'b1;
    step();

    // Fill all entries with distinct lines.
    for (int k = 0; k < DEPTH; k++) begin
      offer(48'h1000 + 48'(k * 64), k, 1'b0);
      #1 check("fill_idx", 64'(bus.alloc_idx), 64'(k));
      $display("txn fill k=%0d idx=%0d", k, bus.alloc_idx);
      step();
    end
    offer(48'h1400, 99, 1'b0);
    #1;
    check("fill_count", 64'(bus.count), 64'd16);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_ready", 64'(bus.alloc_ready), 64'd0);
    bus.alloc_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.done_valid = 1'b1; bus.done_idx = IDX_W'(k);
      step();
    end
    bus.done_valid = 1'b0;
    #1 check("drain_count", 64'(bus.count), 64'd0);
    $display("txn drain count=%0d", bus.count);

    // Same-line hazard and release.
    offer(48'h2000, 1, 1'b0);
    #1 check("hz_first_idx", 64'(bus.alloc_idx), 64'd0);
    step();
    offer(48'h2010, 2, 1'b0);
    #1 check("hz_hazard", 64'(bus.alloc_hazard), 64'd1);
    check("hz_ready", 64'(bus.alloc_ready), 64'd0);
    bus.done_valid = 1'b1; bus.done_idx = '0;
    #1 check("hz_freeing", 64'(bus.alloc_hazard), 64'd1);
    step();
    bus.done_valid = 1'b0;
    #1 check("hz_cleared", 64'(bus.alloc_hazard), 64'd0);
    check("hz_reuse_idx", 64'(bus.alloc_idx), 64'd0);
    $display("txn hazard released idx=%0d", bus.alloc_idx);
    step();
    bus.alloc_valid = 1'b0; bus.done_valid = 1'b1; bus.done_idx = '0;
    step();
    bus.done_valid = 1'b0;

    // ExpCompAck path on entry 3.
    for (int k = 0; k < 4; k++) begin
      offer(48'h3000 + 48'(k * 64), 16 + k, k == 3);
      step();
    end
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b1; bus.done_idx = IDX_W'(3);
    step();
    bus.done_valid = 1'b0;
    #1 check("ack_wait_count", 64'(bus.count), 64'd4);
    check("ack_wait_err", 64'(bus.err), 64'd0);
    bus.compack_valid = 1'b1; bus.compack_idx = IDX_W'(3);
    step();
    bus.compack_valid = 1'b0;
    #1 check("ack_done_count", 64'(bus.count), 64'd3);
    check("ack_done_err", 64'(bus.err), 64'd0);
    $display("txn compack idx=3 count=%0d", bus.count);

    // Protocol violations.
    for (int k = 0; k < 3; k++) begin
      offer(48'h3100 + 48'(k * 64), 32 + k, 1'b0);
      #1 check("viol_idx", 64'(bus.alloc_idx), 64'(3 + k));
      step();
    end
    bus.alloc_valid = 1'b0;
    bus.compack_valid = 1'b1; bus.compack_idx = IDX_W'(5);
    step();
    bus.compack_valid = 1'b0;
    #1 check("viol_ack_err", 64'(bus.err), 64'd1);
    check("viol_ack_count", 64'(bus.count), 64'd6);
    step();
    #1 check("viol_ack_err_clr", 64'(bus.err), 64'd0);
    bus.done_valid = 1'b1; bus.done_idx = IDX_W'(7);
    step();
    bus.done_valid = 1'b0;
    #1 check("viol_done_err", 64'(bus.err), 64'd1);
    check("viol_done_count", 64'(bus.count), 64'd6);
    $display("txn violations err=%0d count=%0d", bus.err, bus.count);
    step();
    #1 check("viol_done_err_clr", 64'(bus.err), 64'd0);

    // Full queue with simultaneous done, CompAck and offered allocation.
    for (int k = 6; k < DEPTH; k++) begin
      offer(48'h4000 + 48'(k * 64), 48 + k, k == 9);
      #1 check("full_fill_idx", 64'(bus.alloc_idx), 64'(k));
      step();
    end
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b1; bus.done_idx = IDX_W'(9);
    step();
    bus.done_valid = 1'b0;
    #1 check("full_count16", 64'(bus.count), 64'd16);
    bus.done_valid = 1'b1; bus.done_idx = IDX_W'(2);
    bus.compack_valid = 1'b1; bus.compack_idx = IDX_W'(9);
    offer(48'h5000, 70, 1'b0);
    #1 check("full_ready0", 64'(bus.alloc_ready), 64'd0);
    step();
    bus.done_valid = 1'b0; bus.compack_valid = 1'b0;
    #1 check("full_count14", 64'(bus.count), 64'd14);
    check("full_reuse_idx", 64'(bus.alloc_idx), 64'd2);
    $display("txn dual free count=%0d next_idx=%0d", bus.count, bus.alloc_idx);
    step();
    bus.alloc_valid = 1'b0;
    #1 check("full_count15", 64'(bus.count), 64'd15);

    // Reset mid-stream with 4 live entries.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(48'h6000 + 48'(k * 64), 80 + k, 1'b0);
      step();
    end
    bus.alloc_valid = 1'b0;
    #1 check("mid_count4", 64'(bus.count), 64'd4);
    reset = 1'b0;
    #1;
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    check("mid_rst_ready", 64'(bus.alloc_ready), 64'd1);
    $display("txn mid reset count=%0d empty=%0d", bus.count, bus.empty);
    step();
    reset = 1'b1;
    offer(48'h7000, 90, 1'b1);
    bus.compack_valid = 1'b1; bus.compack_idx = IDX_W'(1);
    #1 check("post_rst_idx", 64'(bus.alloc_idx), 64'd0);
    step();
    bus.alloc_valid = 1'b0; bus.compack_valid = 1'b0;
    #1 check("post_rst_ack_err", 64'(bus.err), 64'd1);
    check("post_rst_count", 64'(bus.count), 64'd1);

    // Same-index done and CompAck: done applies, CompAck flags.
    bus.done_valid = 1'b1; bus.done_idx = '0;
    bus.compack_valid = 1'b1; bus.compack_idx = '0;
    step();
    bus.done_valid = 1'b0; bus.compack_valid = 1'b0;
    #1 check("same_idx_err", 64'(bus.err), 64'd1);
    check("same_idx_count", 64'(bus.count), 64'd1);
    bus.compack_valid = 1'b1; bus.compack_idx = '0;
    step();
    bus.compack_valid = 1'b0;
    #1 check("same_idx_free", 64'(bus.count), 64'd0);
    check("same_idx_err_clr", 64'(bus.err), 64'd0);
    $display("txn same idx done+ack count=%0d", bus.count);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
